// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: PC width, instruction width and canonical NOP.
// Pure definitions; no logic, no latency, no flow control.
package riscv_pkg;

  localparam int          XLEN      = 64;
  localparam int          ILEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0, x0, 0

endpackage

// File: rtl/fetch_queue.sv
// Fetch->decode FWFT queue; 1-cycle enq->deq latency, 0 with FETCH_QUEUE_BYPASS_EN on an empty queue.
// Backpressure: enq_ready drops only when full; flush empties the queue and blocks dequeue that cycle.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = riscv_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_valid,
  input  logic [XLEN-1:0]          enq_pc,
  input  logic [ILEN-1:0]          enq_instr,
  output logic                     enq_ready,
  output logic                     deq_valid,
  output logic [XLEN-1:0]          deq_pc,
  output logic [ILEN-1:0]          deq_instr,
  input  logic                     deq_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [ILEN-1:0] instr_mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;

  logic empty;
  logic bypass;
  logic do_enq;
  logic do_deq;

  assign empty     = (count_q == '0);
  assign enq_ready = (count_q != CW'(DEPTH));
  assign count     = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  // An empty queue hands the word straight to decode without storing it.
  assign bypass = empty && enq_valid && deq_ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    deq_valid = !empty && !flush;
    deq_pc    = '0;
    deq_instr = NOP_INSTR;
    if (bypass) begin
      deq_valid = 1'b1;
      deq_pc    = enq_pc;
      deq_instr = enq_instr;
    end else if (deq_valid) begin
      deq_pc    = pc_mem[rd_ptr];
      deq_instr = instr_mem[rd_ptr];
    end
  end

  assign do_enq = enq_valid && enq_ready && !flush && !bypass;
  assign do_deq = deq_valid && deq_ready && !bypass;

  // Storage is left uninitialised; the pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      pc_mem[wr_ptr]    <= enq_pc;
      instr_mem[wr_ptr] <= enq_instr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queue entries; power of two, 2..16.
REQ-002 SHALL have parameter XLEN, default 64, meaning PC width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enq_valid  input  1  fetch stage presents an instruction.
REQ-006 SHALL have port enq_pc  input  XLEN  PC of presented instruction.
REQ-007 SHALL have port enq_instr  input  32  presented instruction word.
REQ-008 SHALL have port enq_ready  output  1  queue accepts this cycle.
REQ-009 SHALL have port deq_valid  output  1  head entry valid toward decode.
REQ-010 SHALL have port deq_pc  output  XLEN  head PC.
REQ-011 SHALL have port deq_instr  output  32  head instruction.
REQ-012 SHALL have port deq_ready  input  1  decode consumes this cycle.
REQ-013 SHALL have port flush  input  1  taken branch from execute; discard all entries.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL enqueue on a clock edge where enq_valid && enq_ready; dequeue where deq_valid && deq_ready.
REQ-016 SHALL drive enq_ready = (count != DEPTH); no enqueue-while-full pass-through.
REQ-017 SHALL present head entry first-word-fall-through: deq_valid = (count != 0), deq_pc/deq_instr combinational from head.
REQ-018 SHALL drive deq_instr = 32'h00000013 (NOP) and deq_pc = 0 while deq_valid = 0.
REQ-019 SHALL keep count unchanged on simultaneous enqueue and dequeue, including at count = DEPTH-1 and at count = 1.
REQ-020 SHALL wrap read/write pointers modulo DEPTH without loss or duplication.
REQ-021 SHALL give flush highest priority: at the edge with flush = 1, count, read and write pointers go to 0; enqueue and dequeue of that cycle are discarded.
REQ-022 SHALL force deq_valid = 0 combinationally in any cycle where flush = 1.
REQ-023 SHALL have enqueue-to-dequeue latency of 1 cycle (entry visible at deq the cycle after acceptance) when bypass is not compiled in.
REQ-024 SHALL preserve strict program order: entries leave in acceptance order.

Reset
REQ-025 SHALL, while reset = 0, asynchronously clear count, pointers; outputs: enq_ready = 1, deq_valid = 0, deq_pc = 0, deq_instr = NOP, count = 0.
REQ-026 SHALL discard all entries if reset asserts mid-operation; storage contents need not be cleared.
REQ-027 SHALL accept an enqueue on the first rising edge after reset deasserts.

Configuration
REQ-028 SHALL honour macro FETCH_QUEUE_BYPASS_EN: when defined, with count = 0, enq_valid = 1, deq_ready = 1, flush = 0, the instruction passes combinationally to deq (deq_valid = 1, zero latency) and is not stored; count stays 0.
REQ-029 SHALL, without FETCH_QUEUE_BYPASS_EN, never make deq_valid depend combinationally on enq_valid.

Structure
REQ-030 SHALL take XLEN default, instruction width 32 and NOP constant 32'h00000013 from shared package riscv_pkg.
REQ-031 SHALL implement storage and pointers inline; no sub-module.

Verification
REQ-032 Reset: reset = 0 mid-stream with count = 3 -> immediately count = 0, deq_valid = 0, deq_instr = 32'h00000013, enq_ready = 1.
REQ-033 Fill/drain: enqueue PCs 0x0,0x4,0x8,0xC with deq_ready = 0 -> count = 4, enq_ready = 0; 5th enqueue ignored; drain -> PCs 0x0..0xC in order, then deq_valid = 0.
REQ-034 Wrap: 10 back-to-back enq+deq with DEPTH = 4, PC 0x100 step 4 -> every PC 0x100..0x124 exits once, in order, count constant.
REQ-035 Flush: count = 3 and enq_valid = 1 with flush = 1 -> next cycle count = 0, new PC not stored; deq_valid = 0 during flush cycle.
REQ-036 Full simultaneous: count = 4, enq_valid = 1, deq_ready = 1 -> head leaves, enqueue rejected, count = 3.
REQ-037 Bypass (macro defined): empty, enq PC 0x200 instr 0x00500093 with deq_ready = 1 -> same-cycle deq_pc = 0x200, deq_instr = 0x00500093, count stays 0; macro undefined -> appears one cycle later.
